hack_control: RTL and testbench

- Sequencer and decoder that sits upstream of the 16-bit Hack ALU.
- Fetches Hack instructions and holds the A, D and PC registers.
- Drives the ALU operands and the zx/nx/zy/ny/f/no control bits, then consumes the ALU's out/zr/ng to write registers, issue data-memory writes and resolve jumps.
- Together with the ALU it forms the CPU core.

---
 rtl/hack_control_if.sv | 32 +++
 rtl/hack_control.sv | 108 ++++++++++
 tb/tb_hack_control.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_control_if.sv
// Bus between the Hack control unit and its surroundings: instruction fetch,
// data memory and the ALU operand/result lines.
interface hack_control_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 15
);
  logic [WIDTH-1:0] instruction;
  logic             instr_valid;
  logic             fetch;
  logic [AW-1:0]    pc;
  logic [WIDTH-1:0] inM;
  logic             mem_ready;
  logic [AW-1:0]    addressM;
  logic [WIDTH-1:0] outM;
  logic             writeM;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [5:0]       alu_ctl;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr;
  logic             alu_ng;

  modport master (
    input  instruction, instr_valid, inM, mem_ready, alu_out, alu_zr, alu_ng,
    output fetch, pc, addressM, outM, writeM, alu_x, alu_y, alu_ctl
  );

  modport slave (
    output instruction, instr_valid, inM, mem_ready, alu_out, alu_zr, alu_ng,
    input  fetch, pc, addressM, outM, writeM, alu_x, alu_y, alu_ctl
  );
endinterface

// File: rtl/hack_control.sv
// Hack CPU sequencer/decoder: fetches instructions, holds A/D/PC, drives the
// external ALU and resolves register writes, memory writes and jumps.
module hack_control #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 15
) (
  input logic            clk,
  input logic            rst_n,
  hack_control_if.master bus
);

  typedef enum logic [1:0] {StFetch, StExec, StMemwr} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] outm_q, outm_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             writem_q, writem_d;
  logic             taken;
  logic             unused_ir;

  // Bits 14:13 of a C-instruction carry no meaning.
  assign unused_ir = ^ir_q[14:13];

  assign taken = (ir_q[2] & bus.alu_ng) | (ir_q[1] & bus.alu_zr) |
                 (ir_q[0] & ~bus.alu_ng & ~bus.alu_zr);

  always_comb begin
    bus.fetch    = (state_q == StFetch);
    bus.pc       = pc_q;
    bus.outM     = outm_q;
    bus.writeM   = writem_q;
    bus.alu_x    = d_q;
    bus.alu_y    = ir_q[12] ? bus.inM : a_q;
    bus.alu_ctl  = ir_q[11:6];
    bus.addressM = (state_q == StMemwr) ? addr_q : a_q[AW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    d_d      = d_q;
    ir_d     = ir_q;
    outm_d   = outm_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    writem_d = writem_q;
    unique case (state_q)
      StFetch: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instruction;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        if (!ir_q[WIDTH-1]) begin
          a_d  = ir_q;
          pc_d = pc_q + AW'(1);
        end else begin
          if (ir_q[5]) a_d = bus.alu_out;
          if (ir_q[4]) d_d = bus.alu_out;
          // Jump target and write address use A as it was before this edge.
          pc_d = taken ? a_q[AW-1:0] : pc_q + AW'(1);
          if (ir_q[3]) begin
            outm_d   = bus.alu_out;
            addr_d   = a_q[AW-1:0];
            writem_d = 1'b1;
            state_d  = StMemwr;
          end
        end
      end
      StMemwr: begin
        if (bus.mem_ready) begin
          writem_d = 1'b0;
          state_d  = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      a_q      <= '0;
      d_q      <= '0;
      ir_q     <= '0;
      outm_q   <= '0;
      pc_q     <= '0;
      addr_q   <= '0;
      writem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      d_q      <= d_d;
      ir_q     <= ir_d;
      outm_q   <= outm_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      writem_q <= writem_d;
    end
  end

endmodule

// File: tb/tb_hack_control.sv
// Scoreboard bench for hack_control: an instruction-level Hack model predicts
// per-fetch state and memory writes; monitors compare against the DUT.
module tb_hack_control;

  logic clk;
  logic rst_n;

  hack_control_if #(.WIDTH(16), .AW(15)) bus ();

  hack_control #(.WIDTH(16), .AW(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] y;
    logic [5:0]  ctl;
  } fetch_rec_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_rec_t;

  fetch_rec_t  fq[$];
  wr_rec_t     wq[$];
  logic [15:0] env_mem [32768];
  logic [15:0] m_mem   [32768];
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  int          total = 0;
  int          bad = 0;
  int          force_delay = -1;
  bit          drop_chk = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? xx + yy : xx & yy;
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign bus.alu_out = hack_alu(bus.alu_x, bus.alu_y, bus.alu_ctl);
  assign bus.alu_zr  = (bus.alu_out == 16'h0);
  assign bus.alu_ng  = bus.alu_out[15];
  assign bus.inM     = env_mem[bus.addressM];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Instruction-level reference: one call = one architectural instruction.
  task automatic model_step(input logic [15:0] ins);
    fetch_rec_t  r;
    logic [15:0] y, o, a_old;
    logic        taken;
    y = ins[12] ? m_mem[m_a[14:0]] : m_a;
    r.pc = m_pc; r.a = m_a; r.d = m_d; r.y = y; r.ctl = ins[11:6];
    fq.push_back(r);
    if (!ins[15]) begin
      m_a  = ins;
      m_pc = m_pc + 15'd1;
    end else begin
      o     = hack_alu(m_d, y, ins[11:6]);
      a_old = m_a;
      taken = (ins[2] && o[15]) || (ins[1] && o == 16'h0) ||
              (ins[0] && !o[15] && o != 16'h0);
      if (ins[5]) m_a = o;
      if (ins[4]) m_d = o;
      if (ins[3]) begin
        m_mem[a_old[14:0]] = o;
        wq.push_back('{addr: a_old[14:0], data: o});
      end
      m_pc = taken ? a_old[14:0] : m_pc + 15'd1;
    end
  endtask

  task automatic issue(input logic [15:0] ins, input int stall);
    int n;
    n = 0;
    while (!bus.fetch && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.fetch) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: fetch stayed 0 for %0d cycles at %0t", n, $time);
      finish_run();
    end
    repeat (stall) begin
      bus.instruction = 16'($urandom);
      @(posedge clk); #1;
    end
    model_step(ins);
    bus.instruction = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instruction = 16'($urandom);
  endtask

  // Data memory responder; also owns the environment memory contents.
  initial begin
    int wcnt;
    wcnt = 0;
    for (int i = 0; i < 32768; i++) env_mem[i] = 16'h0;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      if (rst_n && bus.writeM && bus.mem_ready) env_mem[bus.addressM] = bus.outM;
      #1;
      wcnt = bus.writeM ? wcnt + 1 : 0;
      if (force_delay >= 0) bus.mem_ready = bus.writeM && (wcnt > force_delay);
      else bus.mem_ready = ($urandom_range(0, 2) == 0);
    end
  end

  // Fetch/exec monitor.
  initial begin
    fetch_rec_t r;
    forever begin
      @(negedge clk);
      if (rst_n && bus.fetch && bus.instr_valid) begin
        if (fq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_fetch: pc 0x%0h with empty queue", bus.pc);
        end else begin
          r = fq.pop_front();
          check("fetch_pc", 32'(bus.pc), 32'(r.pc));
          @(negedge clk);
          check("exec_fetch", 32'(bus.fetch), 32'd0);
          check("exec_alu_x", 32'(bus.alu_x), 32'(r.d));
          check("exec_alu_y", 32'(bus.alu_y), 32'(r.y));
          check("exec_alu_ctl", 32'(bus.alu_ctl), 32'(r.ctl));
          check("exec_addressM", 32'(bus.addressM), 32'(r.a[14:0]));
        end
      end
    end
  end

  // Memory write monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (drop_chk) begin
          check("writeM_drop", 32'(bus.writeM), 32'd0);
          drop_chk = 0;
        end
        if (bus.writeM) begin
          if (wq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", bus.addressM, bus.outM);
          end else begin
            check("wr_addr", 32'(bus.addressM), 32'(wq[0].addr));
            check("wr_data", 32'(bus.outM), 32'(wq[0].data));
            if (bus.mem_ready) begin
              void'(wq.pop_front());
              drop_chk = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    total++;
    bad++;
    $display("FAIL watchdog: run exceeded time limit");
    finish_run();
  end

  initial begin
    logic [15:0] ins;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instruction = 16'h0;
    m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
    for (int i = 0; i < 32768; i++) m_mem[i] = 16'h0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_fetch", 32'(bus.fetch), 32'd1);
    check("rst_writeM", 32'(bus.writeM), 32'd0);
    check("rst_outM", 32'(bus.outM), 32'h0);
    @(posedge clk); #1;

    // Register load, then a 3-cycle stall in FETCH.
    issue(16'h0005, 0);
    issue(16'hEC10, 0);
    issue(16'h0007, 3);
    // Memory write held for 4 stalled cycles.
    force_delay = 4;
    issue(16'h0010, 0);
    issue(16'hE7C8, 1);
    // AM=D with A=0x20, D=0x1234.
    issue(16'h1234, 0);
    issue(16'hEC10, 0);
    issue(16'h0020, 0);
    issue(16'hE328, 0);
    issue(16'hEC10, 0);
    force_delay = -1;
    // Jumps with A=0x0100.
    issue(16'h0100, 0);
    issue(16'hEA82, 0);
    issue(16'h0100, 0);
    issue(16'hEA81, 0);
    issue(16'h0100, 0);
    issue(16'hEA87, 0);
    issue(16'h0001, 0);
    issue(16'hEC10, 0);
    issue(16'h0100, 0);
    issue(16'hE302, 0);
    // pc wrap.
    issue(16'h7FFF, 0);
    issue(16'hEA87, 0);
    issue(16'h0003, 0);
    issue(16'h0004, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) ins = {1'b0, 15'($urandom)};
      else ins = {3'b111, 13'($urandom)};
      issue(ins, $urandom_range(0, 2));
    end

    begin
      int n;
      n = 0;
      while (!bus.fetch && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
    end
    @(posedge clk); #1;
    check("drain_fetch_q", 32'(fq.size()), 32'd0);
    check("drain_write_q", 32'(wq.size()), 32'd0);

    // Asynchronous reset while a write is stalled.
    force_delay = 1000;
    issue(16'h0030, 0);
    issue(16'hE308, 0);
    @(posedge clk); #1;
    check("memwr_writeM", 32'(bus.writeM), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_writeM", 32'(bus.writeM), 32'd0);
    check("async_fetch", 32'(bus.fetch), 32'd1);
    check("async_pc", 32'(bus.pc), 32'h0);
    // The interrupted write never reached memory.
    while (wq.size() > 0) begin
      m_mem[wq[0].addr] = env_mem[wq[0].addr];
      void'(wq.pop_front());
    end
    m_a = 16'h0; m_d = 16'h0; m_pc = 15'h0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    force_delay = -1;
    issue(16'h0042, 0);
    issue(16'hEC10, 0);
    repeat (4) @(posedge clk);
    #1;
    check("final_pc", 32'(bus.pc), 32'h2);
    finish_run();
  end

endmodule
